spi_slave_os: RTL and testbench

- Next-generation SPI slave, fully synchronous to one system clock.
- sck, cs and mosi are oversampled through 2-flop synchronisers, replacing the sck-clocked shift registers.
- Parametrised word width, runtime-selectable SPI mode (CPOL/CPHA), MSB/LSB-first, and back-to-back multi-word frames under one cs assertion.
- Sits between an off-chip SPI master and on-chip logic via a valid/ready TX holding register and a one-cycle RX strobe.

---
 rtl/spi_pkg.sv | 24 ++
 rtl/spi_sync_edge.sv | 31 +++
 rtl/spi_slave_os.sv | 228 ++++++++++++++++++++++
 tb/tb_spi_slave_os.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared definitions for the oversampled SPI slave.
//   state_t      : frame FSM states (IDLE, ACTIVE)
//   MODE0..MODE3 : SPI mode encodings as {cpol, cpha}
//   data_w_ok()  : legal range check for the word-width parameter
package spi_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  localparam logic [1:0] MODE0 = 2'b00;
  localparam logic [1:0] MODE1 = 2'b01;
  localparam logic [1:0] MODE2 = 2'b10;
  localparam logic [1:0] MODE3 = 2'b11;

  localparam int unsigned DATA_W_MIN = 2;
  localparam int unsigned DATA_W_MAX = 32;

  function automatic bit data_w_ok(input int unsigned w);
    return (w >= DATA_W_MIN) && (w <= DATA_W_MAX);
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser with edge pulses.
//   clk, rst  : system clock, async active-high reset
//   rst_val_i : value every stage takes during reset
//   d_i       : asynchronous input
//   q_o       : synchronised level (oldest stage)
//   rise_o    : one-cycle pulse, 0->1 seen across the last two stages
//   fall_o    : one-cycle pulse, 1->0 seen across the last two stages
module spi_sync_edge #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic rst_val_i,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= {STAGES{rst_val_i}};
    else     sync_q <= {sync_q[STAGES-2:0], d_i};
  end

  assign q_o    = sync_q[STAGES-1];
  assign rise_o =  sync_q[STAGES-2] & ~sync_q[STAGES-1];
  assign fall_o = ~sync_q[STAGES-2] &  sync_q[STAGES-1];

endmodule

// File: rtl/spi_slave_os.sv
// Oversampled SPI slave, fully synchronous to clk.
//   clk, rst          : system clock (>= 4x sck), async active-high reset
//   cpol, cpha        : SPI mode, latched when a frame starts
//   sck, cs, mosi     : asynchronous SPI master signals (cs active low)
//   miso, miso_oe     : slave data out and its enable (low while idle)
//   tx_data/valid/ready : valid/ready handshake into the TX holding register
//   rx_data, rx_valid : last received word and its one-cycle strobe
//   tx_underrun       : pulse when a word starts with no TX data available
//   frame_abort       : pulse when cs rises mid-word
module spi_slave_os
  import spi_pkg::*;
#(
  parameter int unsigned DATA_W      = 8,
  parameter bit          MSB_FIRST   = 1'b1,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpol,
  input  logic              cpha,
  input  logic              sck,
  input  logic              cs,
  input  logic              mosi,
  output logic              miso,
  output logic              miso_oe,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              tx_underrun,
  output logic              frame_abort
);

  localparam int unsigned       CNT_W      = $clog2(DATA_W);
  localparam int unsigned       FL_W       = $clog2(SYNC_STAGES + 1);
  localparam logic [CNT_W-1:0]  LAST_BIT   = CNT_W'(DATA_W - 1);
  localparam logic [FL_W-1:0]   FLUSH_DONE = FL_W'(SYNC_STAGES);

  if (!data_w_ok(DATA_W)) begin : g_bad_data_w
    $error("spi_slave_os: DATA_W out of range");
  end

  logic sck_rise, sck_fall, cs_lvl, cs_rise, cs_fall, mosi_s;
  logic unused_sck_lvl, unused_mosi_rise, unused_mosi_fall;

  spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sck_sync (
    .clk(clk), .rst(rst), .rst_val_i(cpol), .d_i(sck),
    .q_o(unused_sck_lvl), .rise_o(sck_rise), .fall_o(sck_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES)) u_cs_sync (
    .clk(clk), .rst(rst), .rst_val_i(1'b1), .d_i(cs),
    .q_o(cs_lvl), .rise_o(cs_rise), .fall_o(cs_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES)) u_mosi_sync (
    .clk(clk), .rst(rst), .rst_val_i(1'b0), .d_i(mosi),
    .q_o(mosi_s), .rise_o(unused_mosi_rise), .fall_o(unused_mosi_fall)
  );

  state_t            state_q, state_d;
  logic              cpol_q, cpol_d, cpha_q, cpha_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              skip_q, skip_d, reload_q, reload_d, pend_q, pend_d;
  logic [DATA_W-1:0] tx_sh_q, tx_sh_d, rx_sh_q, rx_sh_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d, hold_q, hold_d;
  logic              rx_valid_q, rx_valid_d, hold_full_q, hold_full_d;
  logic [FL_W-1:0]   flush_q, flush_d;
  logic              armed_q, armed_d;

  logic              sample_e, shift_e, start, stop, cap, load;
  logic [DATA_W-1:0] rx_word;

  always_comb begin
    sample_e = 1'b0;
    shift_e  = 1'b0;
    unique case ({cpol_q, cpha_q})
      MODE0: begin sample_e = sck_rise; shift_e = sck_fall; end
      MODE1: begin sample_e = sck_fall; shift_e = sck_rise; end
      MODE2: begin sample_e = sck_fall; shift_e = sck_rise; end
      MODE3: begin sample_e = sck_rise; shift_e = sck_fall; end
    endcase
  end

  // The cs synchroniser resets to 1, so a low cs held through reset would look
  // like a fresh falling edge; frames only start once a real high has been seen.
  assign start = (state_q == IDLE) & cs_fall & armed_q;
  assign stop  = (state_q == ACTIVE) & cs_rise;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:   if (start)   state_d = ACTIVE;
      ACTIVE: if (cs_rise) state_d = IDLE;
    endcase
  end

  always_comb begin
    cpol_d      = cpol_q;
    cpha_d      = cpha_q;
    cnt_d       = cnt_q;
    skip_d      = skip_q;
    reload_d    = reload_q;
    pend_d      = pend_q;
    tx_sh_d     = tx_sh_q;
    rx_sh_d     = rx_sh_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    load        = 1'b0;
    cap         = tx_valid & ~hold_full_q;
    rx_word     = MSB_FIRST ? {rx_sh_q[DATA_W-2:0], mosi_s}
                            : {mosi_s, rx_sh_q[DATA_W-1:1]};
    flush_d     = (flush_q == FLUSH_DONE) ? flush_q : flush_q + 1'b1;
    armed_d     = armed_q | ((flush_q == FLUSH_DONE) & cs_lvl);

    if (start) begin
      cpol_d   = cpol;
      cpha_d   = cpha;
      skip_d   = cpha;
      cnt_d    = '0;
      reload_d = 1'b0;
      load     = 1'b1;
    end else if (stop) begin
      cnt_d    = '0;
      skip_d   = 1'b0;
      reload_d = 1'b0;
      pend_d   = 1'b0;
    end else if (state_q == ACTIVE) begin
      if (sample_e) begin
        rx_sh_d = rx_word;
        if (cnt_q == '0) pend_d = 1'b0;
        if (cnt_q == LAST_BIT) begin
          cnt_d      = '0;
          rx_data_d  = rx_word;
          rx_valid_d = 1'b1;
          reload_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      if (shift_e) begin
        if (skip_q) begin
          skip_d = 1'b0;
        end else if (reload_q) begin
          reload_d = 1'b0;
          load     = 1'b1;
        end else begin
          tx_sh_d = MSB_FIRST ? {tx_sh_q[DATA_W-2:0], 1'b0}
                              : {1'b0, tx_sh_q[DATA_W-1:1]};
        end
      end
    end

    // An empty load only arms the underrun flag; the pulse fires when the
    // word's first bit is actually sampled, so the speculative reload after a
    // frame's last word (cs about to rise) does not report an underrun.
    if (load) begin
      if (hold_full_q) begin
        tx_sh_d     = hold_q;
        hold_full_d = 1'b0;
        pend_d      = 1'b0;
      end else if (cap) begin
        tx_sh_d = tx_data;
        pend_d  = 1'b0;
      end else begin
        tx_sh_d = '0;
        pend_d  = 1'b1;
      end
    end else if (cap) begin
      hold_d      = tx_data;
      hold_full_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cpol_q      <= 1'b0;
      cpha_q      <= 1'b0;
      cnt_q       <= '0;
      skip_q      <= 1'b0;
      reload_q    <= 1'b0;
      pend_q      <= 1'b0;
      tx_sh_q     <= '0;
      rx_sh_q     <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      flush_q     <= '0;
      armed_q     <= 1'b0;
    end else begin
      cpol_q      <= cpol_d;
      cpha_q      <= cpha_d;
      cnt_q       <= cnt_d;
      skip_q      <= skip_d;
      reload_q    <= reload_d;
      pend_q      <= pend_d;
      tx_sh_q     <= tx_sh_d;
      rx_sh_q     <= rx_sh_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      flush_q     <= flush_d;
      armed_q     <= armed_d;
    end
  end

  always_comb begin
    miso_oe     = (state_q == ACTIVE) & ~cs_rise;
    miso        = miso_oe & (MSB_FIRST ? tx_sh_q[DATA_W-1] : tx_sh_q[0]);
    frame_abort = stop & (cnt_q != '0);
    tx_underrun = (state_q == ACTIVE) & ~cs_rise & sample_e & (cnt_q == '0) & pend_q;
  end

  assign tx_ready = ~hold_full_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;

endmodule

// File: tb/tb_spi_slave_os.sv
module tb_spi_slave_os;

  localparam int HALF = 40;

  logic clk, rst, cpol, cpha, sck, mosi, cs8, cs16;
  logic miso8, oe8, tx_valid8, tx_ready8, rx_valid8, und8, abort8;
  logic [7:0] tx_data8, rx_data8;
  logic miso16, oe16, tx_valid16, tx_ready16, rx_valid16, und16, abort16;
  logic [15:0] tx_data16, rx_data16;

  spi_slave_os #(.DATA_W(8), .MSB_FIRST(1'b1), .SYNC_STAGES(2)) u_dut8 (
    .clk(clk), .rst(rst), .cpol(cpol), .cpha(cpha), .sck(sck), .cs(cs8), .mosi(mosi),
    .miso(miso8), .miso_oe(oe8), .tx_data(tx_data8), .tx_valid(tx_valid8),
    .tx_ready(tx_ready8), .rx_data(rx_data8), .rx_valid(rx_valid8),
    .tx_underrun(und8), .frame_abort(abort8)
  );

  spi_slave_os #(.DATA_W(16), .MSB_FIRST(1'b0), .SYNC_STAGES(2)) u_dut16 (
    .clk(clk), .rst(rst), .cpol(cpol), .cpha(cpha), .sck(sck), .cs(cs16), .mosi(mosi),
    .miso(miso16), .miso_oe(oe16), .tx_data(tx_data16), .tx_valid(tx_valid16),
    .tx_ready(tx_ready16), .rx_data(rx_data16), .rx_valid(rx_valid16),
    .tx_underrun(und16), .frame_abort(abort16)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int pass_cnt = 0;
  int tot_cnt  = 0;

  int rxv_cnt8 = 0, und_cnt8 = 0, abort_cnt8 = 0;
  int rxv_cnt16 = 0, und_cnt16 = 0, abort_cnt16 = 0, oe_viol = 0;
  logic [7:0]  rx_log8 [8];
  logic [15:0] last_rx16 = '0;

  always @(negedge clk) begin
    if (rx_valid8) begin
      rx_log8[3'(rxv_cnt8)] = rx_data8;
      rxv_cnt8++;
    end
    if (rx_valid16) begin
      last_rx16 = rx_data16;
      rxv_cnt16++;
    end
    und_cnt8    += int'(und8);
    abort_cnt8  += int'(abort8);
    und_cnt16   += int'(und16);
    abort_cnt16 += int'(abort16);
    if ((!oe8 && miso8) || (!oe16 && miso16)) oe_viol++;
  end

  logic [15:0] mo_w [4];
  logic [15:0] mi_w [4];
  int viol;

  // SPI master: words from mo_w, captured miso into mi_w; the final word
  // carries last_bits bits. viol counts miso changes seen on a sample edge.
  task automatic spi_frame(input bit pol, input bit pha, input int nwords,
                           input int nbits, input int last_bits,
                           input bit lsb, input bit wide);
    logic [15:0] mi;
    logic mpre;
    int nb, idx;
    cpol = pol;
    cpha = pha;
    sck  = pol;
    viol = 0;
    #(HALF);
    if (wide) cs16 = 1'b0; else cs8 = 1'b0;
    #(3*HALF);
    for (int w = 0; w < nwords; w++) begin
      nb = (w == nwords - 1) ? last_bits : nbits;
      mi = '0;
      for (int b = 0; b < nb; b++) begin
        idx = lsb ? b : nbits - 1 - b;
        if (!pha) begin
          mosi = mo_w[2'(w)][4'(idx)];
          #(HALF);
          mpre = wide ? miso16 : miso8;
          mi[4'(idx)] = mpre;
          sck = ~pol;
          #(HALF);
          if ((wide ? miso16 : miso8) !== mpre) viol++;
          sck = pol;
        end else begin
          sck  = ~pol;
          mosi = mo_w[2'(w)][4'(idx)];
          #(HALF);
          mpre = wide ? miso16 : miso8;
          mi[4'(idx)] = mpre;
          sck = pol;
          #(HALF);
          if ((wide ? miso16 : miso8) !== mpre) viol++;
        end
      end
      mi_w[2'(w)] = mi;
    end
    #(HALF);
    if (wide) cs16 = 1'b1; else cs8 = 1'b1;
    #(60);
  endtask

  task automatic push8(input logic [7:0] d);
    @(negedge clk);
    tx_data8  = d;
    tx_valid8 = 1'b1;
    @(negedge clk);
    tx_valid8 = 1'b0;
  endtask

  task automatic push16(input logic [15:0] d);
    @(negedge clk);
    tx_data16  = d;
    tx_valid16 = 1'b1;
    @(negedge clk);
    tx_valid16 = 1'b0;
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    tot_cnt++;
    if ({miso8, oe8, tx_ready8, rx_valid8, und8, abort8} !== 6'b001000)
      $display("FAIL reset_flags8: got %b expected 001000", {miso8, oe8, tx_ready8, rx_valid8, und8, abort8});
    else pass_cnt++;
    tot_cnt++;
    if (rx_data8 !== 8'h00) $display("FAIL reset_rx8: got %h expected 00", rx_data8);
    else pass_cnt++;
    tot_cnt++;
    if ({rx_data16, tx_ready16, oe16} !== {16'h0000, 1'b1, 1'b0})
      $display("FAIL reset_16: got %h/%b/%b expected 0000/1/0", rx_data16, tx_ready16, oe16);
    else pass_cnt++;
    rst = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_mode0;
    int r0, u0;
    push8(8'hA5);
    tot_cnt++;
    if (tx_ready8 !== 1'b0) $display("FAIL m0_hold_full: tx_ready got %b expected 0", tx_ready8);
    else pass_cnt++;
    r0 = rxv_cnt8; u0 = und_cnt8;
    mo_w[0] = 16'h003C;
    spi_frame(1'b0, 1'b0, 1, 8, 8, 1'b0, 1'b0);
    tot_cnt++;
    if (mi_w[0][7:0] !== 8'hA5) $display("FAIL m0_miso: got %h expected a5", mi_w[0][7:0]);
    else pass_cnt++;
    tot_cnt++;
    if (rxv_cnt8 - r0 !== 1) $display("FAIL m0_rxv_count: got %0d expected 1", rxv_cnt8 - r0);
    else pass_cnt++;
    tot_cnt++;
    if (rx_log8[3'(r0)] !== 8'h3C) $display("FAIL m0_rx: got %h expected 3c", rx_log8[3'(r0)]);
    else pass_cnt++;
    tot_cnt++;
    if (und_cnt8 - u0 !== 0) $display("FAIL m0_underrun: got %0d expected 0", und_cnt8 - u0);
    else pass_cnt++;
    tot_cnt++;
    if ({tx_ready8, viol != 0} !== 2'b10) $display("FAIL m0_ready_edges: got ready=%b viol=%0d expected 1/0", tx_ready8, viol);
    else pass_cnt++;
  endtask

  task automatic test_modes;
    int r0, u0;
    for (int m = 1; m < 4; m++) begin
      push8(8'h5A);
      r0 = rxv_cnt8; u0 = und_cnt8;
      mo_w[0] = 16'h00C3;
      spi_frame(m[1], m[0], 1, 8, 8, 1'b0, 1'b0);
      tot_cnt++;
      if (mi_w[0][7:0] !== 8'h5A) $display("FAIL mode%0d_miso: got %h expected 5a", m, mi_w[0][7:0]);
      else pass_cnt++;
      tot_cnt++;
      if (rxv_cnt8 - r0 !== 1 || rx_log8[3'(r0)] !== 8'hC3)
        $display("FAIL mode%0d_rx: got %h x%0d expected c3 x1", m, rx_log8[3'(r0)], rxv_cnt8 - r0);
      else pass_cnt++;
      tot_cnt++;
      if (viol !== 0) $display("FAIL mode%0d_shift_edge: got %0d sample-edge changes expected 0", m, viol);
      else pass_cnt++;
      tot_cnt++;
      if (und_cnt8 - u0 !== 0) $display("FAIL mode%0d_underrun: got %0d expected 0", m, und_cnt8 - u0);
      else pass_cnt++;
    end
  endtask

  task automatic test_multiword;
    int r0, u0, k;
    push8(8'h10);
    r0 = rxv_cnt8; u0 = und_cnt8;
    mo_w[0] = 16'h0001; mo_w[1] = 16'h0002; mo_w[2] = 16'h0003;
    k = 0;
    fork
      spi_frame(1'b0, 1'b0, 3, 8, 8, 1'b0, 1'b0);
      begin
        while (tx_ready8 !== 1'b1 && k < 400) begin
          @(negedge clk);
          k++;
        end
        if (k < 400) push8(8'h20);
      end
    join
    tot_cnt++;
    if (k >= 400) $display("FAIL mw_refill_wait: got timeout expected tx_ready");
    else pass_cnt++;
    tot_cnt++;
    if ({mi_w[0][7:0], mi_w[1][7:0], mi_w[2][7:0]} !== 24'h102000)
      $display("FAIL mw_miso: got %h %h %h expected 10 20 00", mi_w[0][7:0], mi_w[1][7:0], mi_w[2][7:0]);
    else pass_cnt++;
    tot_cnt++;
    if (rxv_cnt8 - r0 !== 3) $display("FAIL mw_rxv_count: got %0d expected 3", rxv_cnt8 - r0);
    else pass_cnt++;
    tot_cnt++;
    if ({rx_log8[3'(r0)], rx_log8[3'(r0 + 1)], rx_log8[3'(r0 + 2)]} !== 24'h010203)
      $display("FAIL mw_rx_order: got %h %h %h expected 01 02 03", rx_log8[3'(r0)], rx_log8[3'(r0 + 1)], rx_log8[3'(r0 + 2)]);
    else pass_cnt++;
    tot_cnt++;
    if (und_cnt8 - u0 !== 1) $display("FAIL mw_underrun: got %0d expected 1", und_cnt8 - u0);
    else pass_cnt++;
  endtask

  task automatic test_abort;
    int r0, a0;
    r0 = rxv_cnt8; a0 = abort_cnt8;
    mo_w[0] = 16'h00FF;
    spi_frame(1'b0, 1'b0, 1, 8, 5, 1'b0, 1'b0);
    tot_cnt++;
    if (abort_cnt8 - a0 !== 1) $display("FAIL abort_pulse: got %0d expected 1", abort_cnt8 - a0);
    else pass_cnt++;
    tot_cnt++;
    if (rxv_cnt8 - r0 !== 0) $display("FAIL abort_no_rx: got %0d expected 0", rxv_cnt8 - r0);
    else pass_cnt++;
    push8(8'h96);
    r0 = rxv_cnt8; a0 = abort_cnt8;
    spi_frame(1'b0, 1'b0, 1, 8, 8, 1'b0, 1'b0);
    tot_cnt++;
    if (rxv_cnt8 - r0 !== 1 || rx_log8[3'(r0)] !== 8'hFF)
      $display("FAIL abort_next_rx: got %h x%0d expected ff x1", rx_log8[3'(r0)], rxv_cnt8 - r0);
    else pass_cnt++;
    tot_cnt++;
    if (mi_w[0][7:0] !== 8'h96 || abort_cnt8 - a0 !== 0)
      $display("FAIL abort_next_tx: got %h aborts=%0d expected 96/0", mi_w[0][7:0], abort_cnt8 - a0);
    else pass_cnt++;
  endtask

  task automatic test_lsb16;
    int r0, u0;
    push16(16'h1234);
    r0 = rxv_cnt16; u0 = und_cnt16;
    mo_w[0] = 16'h8001;
    spi_frame(1'b0, 1'b0, 1, 16, 16, 1'b1, 1'b1);
    tot_cnt++;
    if (rxv_cnt16 - r0 !== 1 || last_rx16 !== 16'h8001)
      $display("FAIL lsb16_rx: got %h x%0d expected 8001 x1", last_rx16, rxv_cnt16 - r0);
    else pass_cnt++;
    tot_cnt++;
    if (mi_w[0] !== 16'h1234) $display("FAIL lsb16_miso: got %h expected 1234", mi_w[0]);
    else pass_cnt++;
    tot_cnt++;
    if (und_cnt16 - u0 !== 0 || viol !== 0 || abort_cnt16 !== 0)
      $display("FAIL lsb16_misc: got und=%0d viol=%0d abort=%0d expected 0/0/0", und_cnt16 - u0, viol, abort_cnt16);
    else pass_cnt++;
  endtask

  task automatic test_async_reset;
    int r0;
    push8(8'hA5);
    r0 = rxv_cnt8;
    mo_w[0] = 16'h003C;
    fork
      spi_frame(1'b0, 1'b0, 1, 8, 8, 1'b0, 1'b0);
      begin
        #(13*HALF + 3);
        tot_cnt++;
        if (oe8 !== 1'b1) $display("FAIL rst_pre_oe: got %b expected 1", oe8);
        else pass_cnt++;
        rst = 1'b1;
        #1;
        tot_cnt++;
        if ({miso8, oe8, tx_ready8, rx_valid8, und8, abort8} !== 6'b001000)
          $display("FAIL rst_mid_flags: got %b expected 001000", {miso8, oe8, tx_ready8, rx_valid8, und8, abort8});
        else pass_cnt++;
        tot_cnt++;
        if (rx_data8 !== 8'h00) $display("FAIL rst_mid_rx: got %h expected 00", rx_data8);
        else pass_cnt++;
        repeat (3) @(negedge clk);
        rst = 1'b0;
      end
    join
    tot_cnt++;
    if (rxv_cnt8 - r0 !== 0) $display("FAIL rst_no_resume: got %0d rx words expected 0", rxv_cnt8 - r0);
    else pass_cnt++;
    repeat (10) @(negedge clk);
    push8(8'h3C);
    r0 = rxv_cnt8;
    mo_w[0] = 16'h0077;
    spi_frame(1'b0, 1'b0, 1, 8, 8, 1'b0, 1'b0);
    tot_cnt++;
    if (rxv_cnt8 - r0 !== 1 || rx_log8[3'(r0)] !== 8'h77)
      $display("FAIL rst_after_rx: got %h x%0d expected 77 x1", rx_log8[3'(r0)], rxv_cnt8 - r0);
    else pass_cnt++;
    tot_cnt++;
    if (mi_w[0][7:0] !== 8'h3C) $display("FAIL rst_after_miso: got %h expected 3c", mi_w[0][7:0]);
    else pass_cnt++;
  endtask

  initial begin
    rst = 1'b1;
    cpol = 1'b0; cpha = 1'b0; sck = 1'b0; mosi = 1'b0;
    cs8 = 1'b1; cs16 = 1'b1;
    tx_data8 = '0; tx_valid8 = 1'b0;
    tx_data16 = '0; tx_valid16 = 1'b0;
    test_reset;
    test_mode0;
    test_modes;
    test_multiword;
    test_abort;
    test_lsb16;
    test_async_reset;
    tot_cnt++;
    if (oe_viol !== 0) $display("FAIL miso_when_disabled: got %0d cycles expected 0", oe_viol);
    else pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
